// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the sequential multi-cycle arithmetic units.
package shift_add_multiplier_pkg;

  // Default operand width; the product is twice this wide.
  localparam int unsigned DEFAULT_WIDTH = 16;

  // State register width, common with the sequential divider.
  localparam int unsigned STATE_W = 2;

  // Control states; encoding is shared with the divider so one decoder serves both.
  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    MULTIPLY = 2'd1,
    FINISH   = 2'd2
  } mul_state_e;

  // Iteration counter width: must be able to hold the value WIDTH itself.
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage : shift_add_multiplier_pkg

// File: rtl/shift_add_multiplier_shift_add_step.sv
// One shift-and-add iteration: conditionally add the multiplicand into the
// accumulator, then shift {acc, mq} right by one, keeping the carry.
module shift_add_step
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] mq_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] mq_o
);

  logic [WIDTH:0] sum;

  // The accumulator MSB is always zero on entry: the carry was shifted down last step.
  logic unused_acc_msb;
  assign unused_acc_msb = acc_i[WIDTH];

  // Add when the current multiplier LSB is set, then shift the pair right.
  always_comb begin
    sum = {1'b0, acc_i[WIDTH-1:0]};
    if (mq_i[0]) begin
      sum = {1'b0, acc_i[WIDTH-1:0]} + {1'b0, mcand_i};
    end
    acc_o = {1'b0, sum[WIDTH:1]};
    mq_o  = {sum[0], mq_i[WIDTH-1:1]};
  end

endmodule : shift_add_step

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with start/done handshake and
// registered hi/lo product words; one multiplier bit is consumed per cycle.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = count_width(WIDTH);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_mq;

  shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i   (acc_q),
    .mq_i    (mq_q),
    .mcand_i (mcand_q),
    .acc_o   (step_acc),
    .mq_o    (step_mq)
  );

  // State and datapath registers; synchronous reset discards any partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      mq_q      <= '0;
      acc_q     <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      mq_q      <= mq_d;
      acc_q     <= acc_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath control; everything holds unless a state updates it.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mq_d      = mq_q;
    acc_d     = acc_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    busy_d    = busy_q;
    done_d    = done_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = multiplicand;
          mq_d    = multiplier;
          acc_d   = '0;
          count_d = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = MULTIPLY;
        end
      end
      MULTIPLY: begin
        acc_d   = step_acc;
        mq_d    = step_mq;
        count_d = count_q + CNT_W'(1);
        // Leave on the iteration that brings count up to WIDTH.
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        prod_hi_d = acc_q[WIDTH-1:0];
        prod_lo_d = mq_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign product_hi = prod_hi_q;
  assign product_lo = prod_lo_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule : shift_add_multiplier

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

- Sequential unsigned 16×16 shift-and-add multiplier producing a 32-bit product as a high/low word pair.
- Uses the same start/done handshake and the same hi/lo result-register style as the processor's sequential restoring divider.
- Sits beside the divider in the datapath as the multi-cycle MUL unit.
- Takes one operand bit per cycle, so a result is ready 17 cycles after start is accepted.

## Interface
- WIDTH, 16, operand width; product is 2×WIDTH.
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  WIDTH  operand A; captured on the accepting edge.
- multiplier  input  WIDTH  operand B; captured on the accepting edge.
- product_hi  output  WIDTH  upper half of A×B, registered.
- product_lo  output  WIDTH  lower half of A×B, registered.
- busy  output  1  high in MULTIPLY and FINISH.
- done  output  1  high once a result is valid; held until the next accepted start or reset.

## Operation
- Reset (synchronous): state=IDLE, count=0, product_hi=0, product_lo=0, done=0, busy=0, internal registers=0.
- States are IDLE, MULTIPLY and FINISH; 2-bit encoding, IDLE=0.
- IDLE, start=1:
  - mcand←multiplicand, mq←multiplier, acc(WIDTH+1 bits)←0, count←0.
  - done←0; go to MULTIPLY.
  - With start=0, stay in IDLE and hold all outputs.
- MULTIPLY, each cycle while count<WIDTH:
  - sum = mq[0] ? {1'b0,acc[WIDTH-1:0]}+{1'b0,mcand} : {1'b0,acc[WIDTH-1:0]}.
  - {acc,mq} ← {sum,mq} >> 1, i.e. acc←sum>>1 and mq←{sum[0],mq[WIDTH-1:1]}.
  - count←count+1.
  - When count reaches WIDTH, go to FINISH.
- FINISH: product_hi←acc[WIDTH-1:0], product_lo←mq, done←1; go to IDLE.
- Arithmetic:
  - Unsigned only; no overflow is possible.
  - The sum carry is kept in bit WIDTH of acc and shifted back in, never dropped.
- start outside IDLE is ignored: no queueing, no restart, operands unaffected.
- Operand inputs may change freely after the accepting edge.
- product_hi/product_lo change only in FINISH or reset; the previous result stays readable during a new operation.

## Timing
- Accept edge E0: start=1 in IDLE. busy=1 after E0.
- MULTIPLY runs on edges E1..E16. The count check moves to FINISH without an idle iteration: the transition happens on E16.
- FINISH is on edge E17; after E17, done=1, busy=0 and the product is valid. Latency is 17 cycles from the accept edge.
- Back-to-back operation:
  - start=1 in the first cycle done is high is accepted at E18.
  - done drops after E18; the old product is held until the new FINISH.
- Reset asserted on any edge, including mid-MULTIPLY or coincident with start:
  - Reset wins. The partial result is discarded and the outputs take their reset values the cycle after.
  - The first start after reset deasserts is accepted normally.
- count is 5 bits for WIDTH=16; its width is $clog2(WIDTH)+1 in general.

## Structure
- Shared package holds:
  - the state localparams (IDLE, MULTIPLY, FINISH);
  - the default WIDTH;
  - the state encoding, shared with the divider so the control unit decodes both identically.
- One natural sub-module: shift_add_step.
  - Purely combinational. Inputs acc, mq, mcand; outputs next acc and next mq.
  - Unit-testable in isolation.
- The top level holds the FSM, counter and output registers.

## Test plan
- Reset with start=0 for 3 cycles → product_hi=0, product_lo=0, done=0, busy=0.
- multiplicand=3, multiplier=5, start pulse → exactly 17 cycles later done=1, product_hi=0x0000, product_lo=0x000F.
- 0xFFFF × 0xFFFF → product_hi=0xFFFE, product_lo=0x0001. Also 0x1234 × 0x5678 → product_hi=0x0626, product_lo=0x0060.
- 0 × 0xBEEF and 0xBEEF × 1 → 0x0000_0000 and 0x0000_BEEF. Latency is still 17 cycles.
- Start 7×9, hold start high and change the operands to 0xFFFF every cycle while busy → result is 0x0000_003F. Then start in the first done cycle with 2×2 → done drops, then 0x0000_0004 after 17 cycles.
- Start 0x1234×0x5678, assert reset at cycle 8 for 1 cycle → all outputs 0 next cycle, no done. Then 6×7 → 0x0000_002A.
